// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit stage.
// Frame-length helper lets testbenches derive timing from the same parameters.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Cycles from one acceptance edge to the earliest next acceptance edge.
  function automatic int uart_frame_cycles(input int clks_per_bit,
                                           input int data_bits,
                                           input int parity_en,
                                           input int stop_bits);
    return (1 + data_bits + parity_en + stop_bits) * clks_per_bit + 1;
  endfunction

  // Even parity over up to eight data bits; narrower words are zero-extended.
  function automatic logic uart_even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Reloadable bit-period down-counter: tick marks the last cycle of each bit.
// Reloads on load (frame start) or on tick, so bit periods chain without gaps.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  assign tick = (cnt_r == {CNT_W{1'b0}});

  // Bit-period counter: reload on frame start or period end, otherwise count down.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load || tick) begin
      cnt_r <= RELOAD;
    end else begin
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_stage.sv
// UART transmit stage: accepts a word on valid/ready and shifts it out LSB-first
// as start / data / optional even parity / stop bits on a registered serial line.
module uart_tx_stage
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int BIT_CNT_W = 3;

  uart_state_t          state_r;
  uart_state_t          state_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_s;
  logic                 parity_r;
  logic [BIT_CNT_W-1:0] bit_cnt_r;
  logic                 accept_s;
  logic                 done_s;
  logic                 tick_s;
  logic                 tx_s;
  logic                 last_data_s;
  logic                 last_stop_s;

  assign tx_ready    = (state_r == IDLE) && ena;
  assign last_data_s = (bit_cnt_r == BIT_CNT_W'(DATA_BITS - 1));
  assign last_stop_s = (bit_cnt_r == BIT_CNT_W'(STOP_BITS - 1));

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .load (accept_s),
    .tick (tick_s)
  );

  // Next-state logic; bit_cnt_r counts data bits in DATA and stop bits in STOP.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_s  = START;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (tick_s && last_data_s) begin
          state_s = (PARITY_EN != 0) ? PARITY : STOP;
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (tick_s) begin
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (tick_s && last_stop_s) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Shift-register update and serial level for the state being entered, so
  // the registered tx lines up with the bit period that state represents.
  always_comb begin
    shift_s = shift_r;
    tx_s    = 1'b1;
    if (accept_s) begin
      shift_s = tx_data;
    end else if ((state_r == DATA) && tick_s) begin
      shift_s = shift_r >> 1;
    end else begin
      shift_s = shift_r;
    end
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      PARITY:  tx_s = parity_r;
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // State, datapath and registered outputs; reset aborts any frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= {DATA_BITS{1'b0}};
      parity_r   <= 1'b0;
      bit_cnt_r  <= {BIT_CNT_W{1'b0}};
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      if (accept_s) begin
        parity_r <= uart_even_parity(8'(tx_data));
      end else begin
        parity_r <= parity_r;
      end
      if (state_s != state_r) begin
        bit_cnt_r <= {BIT_CNT_W{1'b0}};
      end else if (tick_s && ((state_r == DATA) || (state_r == STOP))) begin
        bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      tx         <= tx_s;
      busy       <= (state_s != IDLE);
      frame_done <= done_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_stage.sv
// Directed bench for uart_tx_stage: an 8N1 and an 8E1 instance at 4 clocks/bit.
// "Cycle n" values are sampled on the falling edge just before rising edge n.
module tb_uart_tx_stage;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] tx_data;
  logic       valid_n, valid_p;
  logic       ready_n, tx_n, busy_n, done_n;
  logic       ready_p, tx_p, busy_p, done_p;
  logic       sel_p;

  int applied = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  uart_tx_stage #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .rst(rst), .ena(ena), .tx_data(tx_data), .tx_valid(valid_n),
    .tx_ready(ready_n), .tx(tx_n), .busy(busy_n), .frame_done(done_n));

  uart_tx_stage #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1)) dut_p (
    .clk(clk), .rst(rst), .ena(ena), .tx_data(tx_data), .tx_valid(valid_p),
    .tx_ready(ready_p), .tx(tx_p), .busy(busy_p), .frame_done(done_p));

  typedef struct {
    logic [7:0]  data;
    bit          par;
    logic [10:0] bits;     // bit k = line level during frame bit k
    int          ena_drop; // cycle at which ena falls, 0 = never
  } vec_t;

  vec_t vecs[8];

  function automatic logic cur_tx();    return sel_p ? tx_p    : tx_n;    endfunction
  function automatic logic cur_busy();  return sel_p ? busy_p  : busy_n;  endfunction
  function automatic logic cur_done();  return sel_p ? done_p  : done_n;  endfunction
  function automatic logic cur_ready(); return sel_p ? ready_p : ready_n; endfunction

  task automatic check(input string name, input int cyc, input logic act, input logic exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int done_cyc;
    done_cyc = uart_frame_cycles(CPB, 8, int'(v.par), 1);
    @(negedge clk);
    sel_p   = v.par;
    tx_data = v.data;
    if (v.par) valid_p = 1'b1; else valid_n = 1'b1;
    #1;
    check("ready_before", 0, cur_ready(), 1'b1);
    check("tx_idle", 0, cur_tx(), 1'b1);
    @(posedge clk);
    for (int c = 1; c <= done_cyc; c++) begin
      @(negedge clk);
      if (c < done_cyc) begin
        check("tx_bit", c, cur_tx(), v.bits[(c - 1) / CPB]);
        check("busy", c, cur_busy(), 1'b1);
        check("no_done", c, cur_done(), 1'b0);
      end else begin
        check("tx_end", c, cur_tx(), 1'b1);
        check("done", c, cur_done(), 1'b1);
        check("busy_end", c, cur_busy(), 1'b0);
        check("ready_end", c, cur_ready(), (v.ena_drop == 0));
      end
      if (c == 1) begin
        valid_n = 1'b0;
        valid_p = 1'b0;
        tx_data = ~v.data;
      end
      if (c == v.ena_drop) ena = 1'b0;
    end
    ena = 1'b1;
  endtask

  initial begin
    logic [10:0] b1, b2, b3c;
    logic        exp;

    vecs[0] = '{8'hA5, 1'b0, 11'({1'b1, 8'hA5, 1'b0}), 0};
    vecs[1] = '{8'h07, 1'b1, 11'({1'b1, 1'b1, 8'h07, 1'b0}), 0};
    vecs[2] = '{8'h00, 1'b0, 11'({1'b1, 8'h00, 1'b0}), 0};
    vecs[3] = '{8'hFF, 1'b0, 11'({1'b1, 8'hFF, 1'b0}), 0};
    vecs[4] = '{8'h3C, 1'b0, 11'({1'b1, 8'h3C, 1'b0}), 0};
    vecs[5] = '{8'h55, 1'b1, 11'({1'b1, 1'b0, 8'h55, 1'b0}), 0};
    vecs[6] = '{8'h80, 1'b1, 11'({1'b1, 1'b1, 8'h80, 1'b0}), 0};
    vecs[7] = '{8'h81, 1'b0, 11'({1'b1, 8'h81, 1'b0}), 10};

    rst = 1'b1; ena = 1'b1; valid_n = 1'b0; valid_p = 1'b0; tx_data = 8'h00; sel_p = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 0, tx_n, 1'b1);
    check("rst_busy", 0, busy_n, 1'b0);
    check("rst_done", 0, done_n, 1'b0);
    check("rst_ready", 0, ready_n, 1'b1);
    check("rst_tx_p", 0, tx_p, 1'b1);
    ena = 1'b0;
    #1;
    check("rst_ready_ena0", 0, ready_n, 1'b0);
    ena = 1'b1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Back-to-back 0x00 then 0xFF with tx_valid held high.
    sel_p = 1'b0;
    b1 = 11'({1'b1, 8'h00, 1'b0});
    b2 = 11'({1'b1, 8'hFF, 1'b0});
    @(negedge clk);
    tx_data = 8'h00;
    valid_n = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 82; c++) begin
      @(negedge clk);
      if (c <= 40)      exp = b1[(c - 1) / CPB];
      else if (c == 41) exp = 1'b1;
      else if (c <= 81) exp = b2[(c - 42) / CPB];
      else              exp = 1'b1;
      check("b2b_tx", c, tx_n, exp);
      check("b2b_done", c, done_n, (c == 41) || (c == 82));
      check("b2b_busy", c, busy_n, !((c == 41) || (c == 82)));
      if (c == 41 || c == 82) check("b2b_ready", c, ready_n, 1'b1);
      if (c == 1)  tx_data = 8'hFF;
      if (c == 42) valid_n = 1'b0;
    end

    // Reset edge at cycle 12 of a 0x3C frame.
    b3c = 11'({1'b1, 8'h3C, 1'b0});
    @(negedge clk);
    tx_data = 8'h3C;
    valid_n = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check("abort_tx", c, tx_n, b3c[(c - 1) / CPB]);
      if (c == 1) valid_n = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx13", 13, tx_n, 1'b1);
    check("abort_busy13", 13, busy_n, 1'b0);
    check("abort_done13", 13, done_n, 1'b0);
    rst = 1'b0;
    for (int c = 14; c <= 50; c++) begin
      @(negedge clk);
      check("abort_no_done", c, done_n, 1'b0);
      check("abort_idle", c, tx_n, 1'b1);
    end
    run_frame(vecs[4]);

    // ena low blocks acceptance.
    sel_p = 1'b0;
    @(negedge clk);
    ena = 1'b0;
    valid_n = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      check("ena0_ready", c, ready_n, 1'b0);
      check("ena0_tx", c, tx_n, 1'b1);
      check("ena0_busy", c, busy_n, 1'b0);
    end
    valid_n = 1'b0;
    ena = 1'b1;

    // ena drops mid-frame; the frame still completes.
    run_frame(vecs[7]);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_stage.md
# uart_tx_stage

Serial output stage for the Tiny Tapeout tile. It sits directly downstream of the tile's core logic. It accepts one data word per valid/ready handshake and shifts it out LSB-first as an asynchronous UART frame on a single pin, which the top-level wrapper drives onto `uo_out[0]`. Frame format and bit period are set by parameters, so the same block serves the cocotb bench (short bit period) and silicon (real baud rate).

## Interface
Parameters:
- `CLKS_PER_BIT`, 87, clock cycles per serial bit (10 MHz / 115200); must be ≥ 2
- `DATA_BITS`, 8, data bits per frame (5–8)
- `PARITY_EN`, 0, 1 = append one even-parity bit after the data bits
- `STOP_BITS`, 1, number of stop bits (1 or 2)

Ports:
- `clk`  in  1  tile clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `ena`  in  1  tile enable; gates acceptance of new words only
- `tx_data`  in  DATA_BITS  word to send; sampled at the handshake
- `tx_valid`  in  1  upstream has a word
- `tx_ready`  out  1  block can accept a word
- `tx`  out  1  serial line; idles high
- `busy`  out  1  high while a frame is in progress
- `frame_done`  out  1  one-cycle pulse when a frame completes

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- `tx_ready = (state == IDLE) && ena`. This is combinational from the state register.
- Handshake: when `tx_valid && tx_ready` at a rising edge, the block latches `tx_data` into the shift register, loads the parity bit (XOR of the data bits), moves to START and loads the baud counter.
- Baud counter: counts `CLKS_PER_BIT-1` down to 0. At 0 the bit period ends (bit tick) and the counter reloads. Counter width is `$clog2(CLKS_PER_BIT)`.
- Transitions:
  - START → DATA on the bit tick.
  - DATA shifts right on each tick. After `DATA_BITS` ticks it goes to PARITY if `PARITY_EN`, otherwise to STOP.
  - PARITY → STOP on one tick.
  - STOP → IDLE after `STOP_BITS` ticks.
- `tx` is registered:
  - 1 in IDLE and STOP
  - 0 in START
  - shift-register bit 0 in DATA
  - the parity bit in PARITY
- `busy` is high in every state except IDLE. `frame_done` is high for the single cycle in which STOP → IDLE is taken.
- Changes on `tx_data` after the handshake have no effect on the frame being sent.
- If `ena` falls mid-frame, the current frame completes normally. No new word is accepted while `ena` is low.
- Reset values: `tx`=1, `busy`=0, `frame_done`=0, state=IDLE, counters=0. During and after reset, `tx_ready` follows `ena`.
- Reset mid-frame: the frame is aborted and the latched data discarded. `tx` is 1 from the cycle after the reset edge, and no `frame_done` pulse is issued.

## Timing
- `NBITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS`.
- Acceptance edge = cycle 0.
- `tx` shows the start bit for cycles 1..CLKS_PER_BIT.
- Bit k (k = 0..NBITS-1) occupies cycles `k*CLKS_PER_BIT+1 .. (k+1)*CLKS_PER_BIT`.
- `frame_done` is high and `tx_ready` returns at cycle `NBITS*CLKS_PER_BIT+1`.
- Back-to-back: with `tx_valid` held high, the next word is accepted at cycle `NBITS*CLKS_PER_BIT+1`, so frames repeat every `NBITS*CLKS_PER_BIT+1` cycles.

## Structure
- Package `uart_pkg`:
  - state enum `uart_state_t`
  - localparam function `uart_frame_cycles(CLKS_PER_BIT, DATA_BITS, PARITY_EN, STOP_BITS)`, which the bench uses for expected timing
- Sub-module `uart_baud_gen`: reloadable down-counter with `load` and `tick` ports, parameterized by `CLKS_PER_BIT`. The FSM, shift register and parity logic remain in `uart_tx_stage`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `ena`=1 unless noted.
- Reset: hold `rst` 3 cycles, `tx_valid`=0 → `tx`=1, `busy`=0, `frame_done`=0, `tx_ready`=1.
- 8N1 frame, `tx_data`=0xA5 → `tx` = 0 (cycles 1–4), then data 1,0,1,0,0,1,0,1 (4 cycles each, cycles 5–36), then 1 (stop, cycles 37–40); `frame_done` pulses at cycle 41.
- `PARITY_EN`=1, `tx_data`=0x07 → parity bit 1 at cycles 37–40, stop at 41–44, `frame_done` at cycle 45.
- Back-to-back 0x00 then 0xFF with `tx_valid` held high → second acceptance at cycle 41, second start bit at cycles 42–45, and no idle-high gap other than that one cycle.
- Reset at cycle 12 of a 0x3C frame → `tx`=1 and `busy`=0 from cycle 13, no `frame_done` pulse. A following 0x3C frame is bit-exact.
- `ena`=0 with `tx_valid`=1 → `tx_ready`=0 and `tx` stays 1 for 50 cycles. Dropping `ena` at cycle 10 of a 0x81 frame → frame completes, `frame_done` at cycle 41.
